// File: rtl/spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl
//   Single-port byte RAM controlled by 10-bit frames from the SPI slave.
//   Frame layout: [9:8] = command, [7:0] = payload.
//     00 WR_ADDR  load write address
//     01 WR_DATA  write payload at write address (optional post-increment)
//     10 RD_ADDR  load read address
//     11 RD_DATA  return mem[read address] on tx_data (optional post-increment)
//
// Ports
//   clk       rising-edge clock, shared with the SPI slave
//   rst       asynchronous reset, active-high
//   rx_data   incoming frame
//   rx_valid  frame qualifier, one frame consumed per cycle high
//   tx_data   registered read byte for the slave to shift out
//   tx_valid  tx_data holds a fresh read result
//   err       sticky flag: data command issued before its address was loaded
// -----------------------------------------------------------------------------
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       err
);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Memory has no reset so that its contents survive rst.
    logic [7:0]           mem [MEM_DEPTH];

    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_ok;
    logic                 rd_ok;

    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] addr;
    logic                 wr_en;

    assign cmd   = rx_data[9:8];
    assign addr  = rx_data[ADDR_SIZE-1:0];
    assign wr_en = rx_valid && (cmd == CMD_WR_DATA) && wr_ok;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= rx_data[7:0];
        end
    end

    // Address wrap is implicit: MEM_DEPTH == 2**ADDR_SIZE, so the
    // ADDR_SIZE-bit increment rolls over from MEM_DEPTH-1 to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            wr_ok    <= 1'b0;
            rd_ok    <= 1'b0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            err      <= 1'b0;
        end else if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr  <= addr;
                    wr_ok    <= 1'b1;
                    tx_valid <= 1'b0;
                end
                CMD_WR_DATA: begin
                    tx_valid <= 1'b0;
                    if (wr_ok) begin
                        if (AUTO_INC != 0) begin
                            wr_addr <= wr_addr + ADDR_SIZE'(1);
                        end
                    end else begin
                        err <= 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    rd_addr  <= addr;
                    rd_ok    <= 1'b1;
                    tx_valid <= 1'b0;
                end
                default: begin
                    // RD_DATA: a write to rd_addr on the previous frame has
                    // already landed, so read-after-write returns new data.
                    if (rd_ok) begin
                        tx_data  <= mem[rd_addr];
                        tx_valid <= 1'b1;
                        if (AUTO_INC != 0) begin
                            rd_addr <= rd_addr + ADDR_SIZE'(1);
                        end
                    end else begin
                        tx_valid <= 1'b0;
                        err      <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
module tb_spi_ram_ctrl;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       err;
        logic       chk_data;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [9:0] rx_data0 = '0;
    logic       rx_valid0 = 1'b0;
    logic [7:0] tx_data0;
    logic       tx_valid0;
    logic       err0;

    logic [9:0] rx_data1 = '0;
    logic       rx_valid1 = 1'b0;
    logic [7:0] tx_data1;
    logic       tx_valid1;
    logic       err1;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data0),
        .rx_valid (rx_valid0),
        .tx_data  (tx_data0),
        .tx_valid (tx_valid0),
        .err      (err0)
    );

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) u_dut_inc (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data1),
        .rx_valid (rx_valid1),
        .tx_data  (tx_data1),
        .tx_valid (tx_valid1),
        .err      (err1)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, req);
        end
    endtask

    task automatic compare(input exp_t e, input logic [7:0] d, input logic v, input logic er);
        check({e.name, ".valid"}, {7'd0, v}, {7'd0, e.valid});
        check({e.name, ".err"}, {7'd0, er}, {7'd0, e.err});
        if (e.chk_data) check({e.name, ".data"}, d, e.data);
    endtask

    // Monitors: after every edge that accepts a frame, pop the expected
    // response for that frame and compare once outputs have settled.
    initial begin
        logic acc;
        exp_t e;
        forever begin
            @(posedge clk);
            acc = rx_valid0 && !rst;
            #1;
            if (acc) begin
                if (q0.size() == 0) begin
                    check("sb0_empty", 8'd1, 8'd0);
                end else begin
                    e = q0.pop_front();
                    compare(e, tx_data0, tx_valid0, err0);
                end
            end
        end
    end

    initial begin
        logic acc;
        exp_t e;
        forever begin
            @(posedge clk);
            acc = rx_valid1 && !rst;
            #1;
            if (acc) begin
                if (q1.size() == 0) begin
                    check("sb1_empty", 8'd1, 8'd0);
                end else begin
                    e = q1.pop_front();
                    compare(e, tx_data1, tx_valid1, err1);
                end
            end
        end
    end

    task automatic send0(input string name, input logic [9:0] f, input logic v,
                         input logic er, input logic chk, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        e.name = name; e.valid = v; e.err = er; e.chk_data = chk; e.data = d;
        q0.push_back(e);
        rx_data0  = f;
        rx_valid0 = 1'b1;
    endtask

    task automatic send1(input string name, input logic [9:0] f, input logic v,
                         input logic er, input logic chk, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        e.name = name; e.valid = v; e.err = er; e.chk_data = chk; e.data = d;
        q1.push_back(e);
        rx_data1  = f;
        rx_valid1 = 1'b1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid0 = 1'b0;
        rx_valid1 = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    // Assert rst between edges while a frame is on the bus and check that
    // outputs clear without any clock edge.
    task automatic async_reset(input string name);
        @(negedge clk);
        rx_data0  = 10'h2A5;
        rx_valid0 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check({name, ".tx_data"}, tx_data0, 8'h00);
        check({name, ".tx_valid"}, {7'd0, tx_valid0}, 8'h00);
        check({name, ".err"}, {7'd0, err0}, 8'h00);
        rx_valid0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #3;
        check("rst0.tx_data", tx_data0, 8'h00);
        check("rst0.tx_valid", {7'd0, tx_valid0}, 8'h00);
        check("rst0.err", {7'd0, err0}, 8'h00);
        check("rst1.tx_data", tx_data1, 8'h00);
        check("rst1.tx_valid", {7'd0, tx_valid1}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Write 0x3C to 0xA5, read it back.
        send0("wr_addr_a5", 10'h0A5, 1'b0, 1'b0, 1'b0, 8'h00); idle(1);
        send0("wr_data_3c", 10'h13C, 1'b0, 1'b0, 1'b0, 8'h00); idle(1);
        send0("rd_addr_a5", 10'h2A5, 1'b0, 1'b0, 1'b0, 8'h00); idle(1);
        send0("rd_data_a5", 10'h300, 1'b1, 1'b0, 1'b1, 8'h3C);

        // Result holds while idle.
        idle(1);
        for (int i = 0; i < 20; i++) begin
            check("hold.tx_valid", {7'd0, tx_valid0}, 8'h01);
            check("hold.tx_data", tx_data0, 8'h3C);
            @(negedge clk);
        end
        send0("clr_wr_addr", 10'h000, 1'b0, 1'b0, 1'b1, 8'h3C);
        send0("wr_data_c3", 10'h1C3, 1'b0, 1'b0, 1'b1, 8'h3C);
        send0("rd_addr_00", 10'h200, 1'b0, 1'b0, 1'b1, 8'h3C);
        send0("rd_data_00", 10'h300, 1'b1, 1'b0, 1'b1, 8'hC3);
        idle(2);

        async_reset("async_rst_a");

        // Data commands before address loads; memory survived reset.
        send0("err_wr_data", 10'h155, 1'b0, 1'b1, 1'b1, 8'h00);
        send0("err_rd_data", 10'h300, 1'b0, 1'b1, 1'b1, 8'h00);
        send0("err_rd_addr", 10'h200, 1'b0, 1'b1, 1'b1, 8'h00);
        send0("err_rd_keep", 10'h300, 1'b1, 1'b1, 1'b1, 8'hC3);
        idle(3);

        async_reset("async_rst_b");

        // Back-to-back frames with read-after-write.
        send0("b2b_wr_addr", 10'h010, 1'b0, 1'b0, 1'b0, 8'h00);
        send0("b2b_wr_data", 10'h177, 1'b0, 1'b0, 1'b0, 8'h00);
        send0("b2b_rd_addr", 10'h210, 1'b0, 1'b0, 1'b0, 8'h00);
        send0("b2b_rd_data", 10'h300, 1'b1, 1'b0, 1'b1, 8'h77);
        send0("b2b_rd_again", 10'h300, 1'b1, 1'b0, 1'b1, 8'h77);
        idle(2);

        // Auto-increment wrap on the second instance.
        send1("inc_wr_addr_ff", 10'h0FF, 1'b0, 1'b0, 1'b0, 8'h00);
        send1("inc_wr_ff", 10'h111, 1'b0, 1'b0, 1'b0, 8'h00);
        send1("inc_wr_00", 10'h122, 1'b0, 1'b0, 1'b0, 8'h00);
        send1("inc_wr_01", 10'h133, 1'b0, 1'b0, 1'b0, 8'h00);
        send1("inc_rd_addr_ff", 10'h2FF, 1'b0, 1'b0, 1'b0, 8'h00);
        send1("inc_rd_ff", 10'h300, 1'b1, 1'b0, 1'b1, 8'h11);
        send1("inc_rd_00", 10'h300, 1'b1, 1'b0, 1'b1, 8'h22);
        send1("inc_rd_01", 10'h300, 1'b1, 1'b0, 1'b1, 8'h33);
        idle(3);

        check("sb0_leftover", 8'(q0.size()), 8'd0);
        check("sb1_leftover", 8'(q1.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

endmodule
